regfile_scan_reader: RTL

REGFILE_SCAN_READER -- requirements
Module: regfile_scan_reader

---
 rtl/regfile_scan_reader_if.sv | 22 ++
 rtl/regfile_scan_reader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/regfile_scan_reader_if.sv
// Bus between the register-file scan reader and its surroundings: the request/pause
// controls, the register-file A read port, and the LED display outputs.
interface regfile_scan_reader_if;
  logic        Start;
  logic        Hold;
  logic [31:0] R_Data;
  logic [4:0]  R_Addr;
  logic [7:0]  LED;
  logic [1:0]  Byte_Sel;
  logic        Busy;
  logic        Done;

  modport master (
    output Start, Hold, R_Data,
    input  R_Addr, LED, Byte_Sel, Busy, Done
  );

  modport slave (
    input  Start, Hold, R_Data,
    output R_Addr, LED, Byte_Sel, Busy, Done
  );
endinterface

// File: rtl/regfile_scan_reader.sv
// Scans register-file words onto an 8-bit LED, one byte per DWELL cycles; Hold stalls
// the scan in place. All outputs are registered. SCAN_SKIP_R0_EN starts the scan at R1.
module regfile_scan_reader #(
  parameter int unsigned DWELL     = 25000000,
  parameter logic [4:0]  LAST_ADDR = 5'd31
) (
  input  logic                 Clk,
  input  logic                 Reset,
  regfile_scan_reader_if.slave bus
);

`ifdef SCAN_SKIP_R0_EN
  localparam logic [4:0] FIRST_ADDR = 5'd1;
`else
  localparam logic [4:0] FIRST_ADDR = 5'd0;
`endif
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    r_addr_q, r_addr_d;
  logic [1:0]    byte_sel_q, byte_sel_d;
  logic [7:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          tc;

  assign tc = (cnt_q == CW'(DWELL - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      r_addr_q   <= 5'd0;
      byte_sel_q <= 2'd0;
      led_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      shadow_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      r_addr_q   <= r_addr_d;
      byte_sel_q <= byte_sel_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.Start) state_d = (FIRST_ADDR > LAST_ADDR) ? DONE : LOAD;
      LOAD:       if (!bus.Hold) state_d = SHOW;
      SHOW: begin
        if (!bus.Hold && tc && byte_sel_q == 2'd3)
          state_d = (r_addr_q < LAST_ADDR) ? LOAD : DONE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    r_addr_d   = r_addr_q;
    byte_sel_d = byte_sel_q;
    led_d      = led_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          // An empty address range jumps straight to DONE without passing LAST_ADDR.
          r_addr_d   = (FIRST_ADDR > LAST_ADDR) ? LAST_ADDR : FIRST_ADDR;
          byte_sel_d = 2'd0;
          cnt_d      = '0;
        end
      end
      LOAD: begin
        if (!bus.Hold) begin
          shadow_d = bus.R_Data;
          led_d    = bus.R_Data[7:0];
          cnt_d    = '0;
        end
      end
      SHOW: begin
        if (!bus.Hold) begin
          if (!tc) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (byte_sel_q != 2'd3) begin
              byte_sel_d = byte_sel_q + 2'd1;
              led_d      = shadow_q[{byte_sel_d, 3'b000} +: 8];
            end else if (r_addr_q < LAST_ADDR) begin
              r_addr_d   = r_addr_q + 5'd1;
              byte_sel_d = 2'd0;
            end
          end
        end
      end
      default: ;
    endcase
    if (state_d == DONE) begin
      led_d      = 8'd0;
      byte_sel_d = 2'd0;
    end
    busy_d = (state_d == LOAD) || (state_d == SHOW);
    done_d = (state_d == DONE);
  end

  assign bus.R_Addr   = r_addr_q;
  assign bus.Byte_Sel = byte_sel_q;
  assign bus.LED      = led_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule
